// File: rtl/block_ram_port_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port block RAM (1-cycle registered read) among N_REQ requesters.
// Latency : RAM strobe 1 cycle after accept; read response 3 cycles after accept; re-accept after 2 (write) / 4 (read) cycles.
// Backpressure: req_ready is held low while an access is in flight; the read response cannot be stalled.
//
// Ports
//   clk, rst_n            : single rising-edge clock, synchronous active-low reset
//   req_valid/req_write   : per-requester request valid and write flag (1=WRITE, 0=READ)
//   req_addr/req_wdata    : packed per-requester address / write data, requester i at [i*W +: W]
//   req_ready             : one-hot accept, combinational in IDLE
//   rsp_valid/rsp_rdata   : one-hot single-cycle read response and its data word
//   ram_en/ram_we         : RAM strobes, high only during the ISSUE cycle
//   ram_addr/ram_wdata    : RAM address / write data, hold their last value outside ISSUE
//   ram_rdata             : RAM read data, valid the cycle after a read strobe
//   busy                  : high whenever the sequencer is not idle
module block_ram_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int N_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_wdata,
  input  logic [DATA_WIDTH-1:0]       ram_rdata,
  output logic                        busy
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_RSP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Arbitration
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic               w_grant_found;
  logic [2*N_REQ-1:0] w_valid_dbl;
  logic [2*N_REQ-1:0] w_valid_rot;
  logic [N_REQ-1:0]   w_ready;
  logic               w_accept;

  // Selected request fields of the granted requester
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_sel_write;

  // Latched in-flight access
  logic [IDX_W-1:0]   r_grant;
  logic               r_wr;
  logic [N_REQ-1:0]   w_grant_onehot;
  logic               w_capture;

  // Registered outputs
  logic                  r_ram_en;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic [N_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  // ---------------------------------------------------------------------------
  // Round-robin search: rotate the valid vector so the pointer lands on bit 0,
  // take the lowest set bit, then rotate the offset back into a requester index.
  // ---------------------------------------------------------------------------
  assign w_valid_dbl = {req_valid, req_valid};
  assign w_valid_rot = w_valid_dbl >> r_ptr;

  always_comb begin
    int v_off;
    int v_sum;
    v_off         = 0;
    v_sum         = 0;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_grant_found && w_valid_rot[k]) begin
        w_grant_found = 1'b1;
        v_off         = k;
      end
    end
    v_sum = int'(r_ptr) + v_off;
    if (v_sum >= N_REQ) begin
      v_sum = v_sum - N_REQ;
    end
    w_grant_idx = IDX_W'(v_sum);
  end

  // Granted requester becomes lowest priority on the next search.
  assign w_ptr_nxt = (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : (w_grant_idx + IDX_W'(1));

  // Field mux and one-hot ready; ready is only offered while idle.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_write = 1'b0;
    w_ready     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_write = req_write[i];
        w_ready[i]  = w_grant_found && (r_state == S_IDLE);
      end
    end
  end

  assign w_accept = |(req_valid & w_ready);

  always_comb begin
    w_grant_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == IDX_W'(i)) begin
        w_grant_onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = r_wr ? S_IDLE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // RAM output register holds the word this cycle.
        w_capture   = 1'b1;
        w_state_nxt = S_RD_RSP;
      end
      S_RD_RSP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and registered outputs. Strobes default low every cycle so
  // they are high only in the cycle following the accept (the ISSUE cycle);
  // address/data registers are only loaded on accept and therefore hold.
  // Synchronous reset abandons any in-flight access and its pending strobe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_grant     <= '0;
      r_wr        <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_grant     <= w_grant_idx;
        r_wr        <= w_sel_write;
        r_ptr       <= w_ptr_nxt;
        r_ram_en    <= 1'b1;
        r_ram_we    <= w_sel_write;
        r_ram_addr  <= w_sel_addr;
        r_ram_wdata <= w_sel_wdata;
      end
      if (w_capture) begin
        r_rsp_rdata <= ram_rdata;
        r_rsp_valid <= w_grant_onehot;
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_block_ram_port_arbiter.sv
// Purpose : directed self-checking bench for block_ram_port_arbiter with a behavioural single-port RAM.
// Latency : checks strobe at t+1, response at t+3, re-accept at t+2 / t+4.
// Backpressure: exercises held requests while busy and simultaneous valids.
module tb_block_ram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int N  = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            ram_en;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;
  logic            busy;

  int n_pass  = 0;
  int n_total = 0;

  block_ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int j = 0; j < N; j++) begin
      if (j == i) begin
        req_valid[j]          = v;
        req_write[j]          = w;
        req_addr[j*AW +: AW]  = a;
        req_wdata[j*DW +: DW] = d;
      end
    end
  endtask

  // Raise a request, wait (bounded) for ready, pass the handshake edge and drop valid.
  // Returns in the ISSUE cycle; waited = cycles spent waiting, -1 on timeout.
  task automatic do_req(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int waited);
    logic [N-1:0] m;
    m = N'(1) << i;
    waited = -1;
    set_req(i, 1'b1, w, a, d);
    for (int n = 0; n < 12; n++) begin
      #1;
      if ((req_ready & m) != '0) begin
        waited = n;
        break;
      end
      step();
    end
    step();
    set_req(i, 1'b0, w, a, d);
  endtask

  // Bounded wait for a response pulse; lat counts cycles from the call.
  task automatic wait_rsp(output logic [N-1:0] v, output logic [DW-1:0] d, output int lat);
    lat = -1;
    v   = '0;
    d   = '0;
    for (int n = 0; n < 8; n++) begin
      if (rsp_valid != '0) begin
        lat = n;
        v   = rsp_valid;
        d   = rsp_rdata;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_total++; if (req_ready !== 2'b00) $display("FAIL reset_ready got %b want 00", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); else n_pass++;
    n_total++; if (rsp_rdata !== 16'h0000) $display("FAIL reset_rsp_rdata got %h want 0000", rsp_rdata); else n_pass++;
    n_total++; if ({ram_en, ram_we} !== 2'b00) $display("FAIL reset_ram_strobes got %b want 00", {ram_en, ram_we}); else n_pass++;
    n_total++; if ({ram_addr, ram_wdata} !== 24'h0) $display("FAIL reset_ram_bus got %h want 000000", {ram_addr, ram_wdata}); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_write_basic();
    rst_n = 1'b1;
    step();
    set_req(0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
    #1;
    n_total++; if (req_ready !== 2'b01) $display("FAIL wr_ready got %b want 01", req_ready); else n_pass++;
    step();
    set_req(0, 1'b0, 1'b1, 8'h10, 16'hBEEF);
    n_total++; if ({ram_en, ram_we} !== 2'b11) $display("FAIL wr_strobe got %b want 11", {ram_en, ram_we}); else n_pass++;
    n_total++; if (ram_addr !== 8'h10) $display("FAIL wr_addr got %h want 10", ram_addr); else n_pass++;
    n_total++; if (ram_wdata !== 16'hBEEF) $display("FAIL wr_wdata got %h want beef", ram_wdata); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL wr_busy got %b want 1", busy); else n_pass++;
    step();
    n_total++; if ({ram_en, busy} !== 2'b00) $display("FAIL wr_done got %b want 00", {ram_en, busy}); else n_pass++;
    n_total++; if (ram_addr !== 8'h10) $display("FAIL wr_addr_hold got %h want 10", ram_addr); else n_pass++;
  endtask

  task automatic test_read();
    int            waited;
    int            lat;
    logic [N-1:0]  v;
    logic [DW-1:0] d;
    do_req(1, 1'b0, 8'h10, 16'h0000, waited);
    n_total++; if (waited !== 0) $display("FAIL rd_accept_wait got %0d want 0", waited); else n_pass++;
    n_total++; if ({ram_en, ram_we} !== 2'b10) $display("FAIL rd_strobe got %b want 10", {ram_en, ram_we}); else n_pass++;
    n_total++; if (ram_addr !== 8'h10) $display("FAIL rd_addr got %h want 10", ram_addr); else n_pass++;
    wait_rsp(v, d, lat);
    n_total++; if (lat !== 2) $display("FAIL rd_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (v !== 2'b10) $display("FAIL rd_rsp_valid got %b want 10", v); else n_pass++;
    n_total++; if (d !== 16'hBEEF) $display("FAIL rd_rdata got %h want beef", d); else n_pass++;
    step();
    n_total++; if (rsp_valid !== 2'b00) $display("FAIL rd_pulse_len got %b want 00", rsp_valid); else n_pass++;
    n_total++; if (rsp_rdata !== 16'hBEEF) $display("FAIL rd_rdata_hold got %h want beef", rsp_rdata); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rd_idle got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]  exp_rdy;
    logic [AW-1:0] exp_addr;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h20, 16'h1111);
    set_req(1, 1'b1, 1'b1, 8'h21, 16'h2222);
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 1) exp_rdy = 2'b00;
      else            exp_rdy = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
      n_total++; if (req_ready !== exp_rdy) $display("FAIL b2b_ready[%0d] got %b want %b", c, req_ready, exp_rdy); else n_pass++;
      if (c % 2 == 1) begin
        exp_addr = ((c / 2) % 2 == 0) ? 8'h20 : 8'h21;
        n_total++;
        if ({ram_en, ram_we, ram_addr} !== {2'b11, exp_addr})
          $display("FAIL b2b_issue[%0d] got en/we/addr %b%b/%h want 11/%h", c, ram_en, ram_we, ram_addr, exp_addr);
        else n_pass++;
      end
      step();
    end
    set_req(0, 1'b0, 1'b1, 8'h20, 16'h1111);
    set_req(1, 1'b0, 1'b1, 8'h21, 16'h2222);
    step();
  endtask

  task automatic test_boundary();
    int            waited;
    int            lat;
    logic [N-1:0]  v;
    logic [DW-1:0] d;
    do_req(0, 1'b1, 8'h00, 16'h0000, waited);
    n_total++; if ({waited == 0, ram_we, ram_addr, ram_wdata} !== {2'b11, 8'h00, 16'h0000})
      $display("FAIL bnd_wr0 got wait %0d we %b addr %h data %h want 0/1/00/0000", waited, ram_we, ram_addr, ram_wdata); else n_pass++;
    step();
    do_req(1, 1'b1, 8'hFF, 16'hFFFF, waited);
    n_total++; if ({waited == 0, ram_we, ram_addr, ram_wdata} !== {2'b11, 8'hFF, 16'hFFFF})
      $display("FAIL bnd_wrff got wait %0d we %b addr %h data %h want 0/1/ff/ffff", waited, ram_we, ram_addr, ram_wdata); else n_pass++;
    step();
    do_req(0, 1'b0, 8'h00, 16'h0000, waited);
    wait_rsp(v, d, lat);
    n_total++; if ({lat == 2, v, d} !== {1'b1, 2'b01, 16'h0000})
      $display("FAIL bnd_rd0 got lat %0d v %b data %h want 2/01/0000", lat, v, d); else n_pass++;
    step();
    do_req(1, 1'b0, 8'hFF, 16'h0000, waited);
    wait_rsp(v, d, lat);
    n_total++; if ({lat == 2, v, d} !== {1'b1, 2'b10, 16'hFFFF})
      $display("FAIL bnd_rdff got lat %0d v %b data %h want 2/10/ffff", lat, v, d); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    int waited;
    do_req(0, 1'b0, 8'h10, 16'h0000, waited);
    n_total++; if ({ram_en, ram_we} !== 2'b10) $display("FAIL rmid_issue got %b want 10", {ram_en, ram_we}); else n_pass++;
    step();
    rst_n = 1'b0;
    step();
    n_total++; if ({rsp_valid, busy, ram_en} !== 4'b0000) $display("FAIL rmid_abort got rsp/busy/en %b%b%b want 00/0/0", rsp_valid, busy, ram_en); else n_pass++;
    n_total++; if (rsp_rdata !== 16'h0000) $display("FAIL rmid_rdata got %h want 0000", rsp_rdata); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (rsp_valid !== 2'b00) $display("FAIL rmid_no_rsp got %b want 00", rsp_valid); else n_pass++;
    set_req(0, 1'b1, 1'b1, 8'h40, 16'h4040);
    set_req(1, 1'b1, 1'b1, 8'h41, 16'h4141);
    #1;
    n_total++; if (req_ready !== 2'b01) $display("FAIL rmid_ptr got %b want 01", req_ready); else n_pass++;
    // Withdraw before any handshake edge: no access may occur.
    set_req(0, 1'b0, 1'b1, 8'h40, 16'h4040);
    set_req(1, 1'b0, 1'b1, 8'h41, 16'h4141);
    step();
    n_total++; if ({ram_en, busy} !== 2'b00) $display("FAIL withdraw got en/busy %b%b want 00", ram_en, busy); else n_pass++;
  endtask

  task automatic test_busy_hold();
    int            waited;
    int            lat;
    logic [N-1:0]  v;
    logic [DW-1:0] d;
    do_req(0, 1'b0, 8'h10, 16'h0000, waited);
    set_req(1, 1'b1, 1'b1, 8'h31, 16'h5A5A);
    #1;
    n_total++; if (req_ready !== 2'b00) $display("FAIL hold_rdy_t1 got %b want 00", req_ready); else n_pass++;
    step();
    n_total++; if (req_ready !== 2'b00) $display("FAIL hold_rdy_t2 got %b want 00", req_ready); else n_pass++;
    step();
    n_total++; if (req_ready !== 2'b00) $display("FAIL hold_rdy_t3 got %b want 00", req_ready); else n_pass++;
    n_total++; if ({rsp_valid, rsp_rdata} !== {2'b01, 16'hBEEF}) $display("FAIL hold_rsp got %b/%h want 01/beef", rsp_valid, rsp_rdata); else n_pass++;
    step();
    n_total++; if ({req_ready, busy} !== 3'b100) $display("FAIL hold_rdy_t4 got rdy/busy %b%b want 10/0", req_ready, busy); else n_pass++;
    step();
    set_req(1, 1'b0, 1'b1, 8'h31, 16'h5A5A);
    n_total++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 8'h31, 16'h5A5A})
      $display("FAIL hold_fields got en/we %b%b addr %h data %h want 11/31/5a5a", ram_en, ram_we, ram_addr, ram_wdata); else n_pass++;
    step();
    do_req(0, 1'b0, 8'h31, 16'h0000, waited);
    wait_rsp(v, d, lat);
    n_total++; if ({v, d} !== {2'b01, 16'h5A5A}) $display("FAIL hold_readback got %b/%h want 01/5a5a", v, d); else n_pass++;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_write_basic();
    test_read();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    test_busy_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
